i8008_bus_responder: RTL and testbench

Memory and I/O responder for the 8-bit `i8008_core` bus; it sits on the far side of the core's `D_out`/`Sync`/`state` outputs and produces the core's `D_in`/`READY`/`INTR` inputs. It decodes the T1/T2 address cycles and serves T3 from an internal byte memory: instruction fetch, memory read, memory write and I/O. It inserts a configurable number of wait states and jams an interrupt instruction during T1I cycles. It replaces hand-driven stimulus in system-level simulation and serves as the memory model for FPGA bring-up.

---
 rtl/i8008_pkg.sv | 38 +++
 rtl/i8008_bus_responder_if.sv | 19 +
 rtl/i8008_bus_mem.sv | 47 ++++
 rtl/i8008_bus_responder.sv | 214 +++++++++++++++++++++
 tb/tb_i8008_bus_responder.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/i8008_pkg.sv
// Shared types and constants for the i8008 bus responder.
// state_t mirrors the core's 3-bit state encoding; cycle_t is the T2 cycle
// type carried in D_out[7:6]; wait_state_t drives the READY wait-state FSM.
package i8008_pkg;

   typedef enum logic [2:0] {
      WAIT    = 3'b000,
      T2      = 3'b001,
      T1      = 3'b010,
      T1I     = 3'b011,
      T3      = 3'b100,
      T5      = 3'b101,
      STOPPED = 3'b110,
      T4      = 3'b111
   } state_t;

   typedef enum logic [1:0] {
      PCI = 2'b00,
      PCR = 2'b01,
      PCC = 2'b10,
      PCW = 2'b11
   } cycle_t;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      COUNT = 2'b01,
      RDY   = 2'b10
   } wait_state_t;

   // Upper two bits of the T2 byte that select an input (INP) I/O cycle.
   localparam logic [1:0] INP_SEL = 2'b00;

   // True when a PCC cycle with this high address byte is an INP.
   function automatic logic is_inp(input logic [5:0] hi);
      return (hi[5:4] == INP_SEL);
   endfunction

endpackage

// File: rtl/i8008_bus_responder_if.sv
// Core-facing bus bundle: the core drives D_out/Sync/state, the responder
// answers with D_in/READY/INTR.
interface i8008_bus_responder_if;
   import i8008_pkg::*;

   logic [7:0] D_out;
   logic       Sync;
   state_t     state;
   logic [7:0] D_in;
   logic       READY;
   logic       INTR;

   modport master (output D_out, output Sync, output state,
                   input  D_in,  input  READY, input  INTR);

   modport slave  (input  D_out, input  Sync, input  state,
                   output D_in,  output READY, output INTR);

endinterface

// File: rtl/i8008_bus_mem.sv
// Single-port synchronous byte RAM. While load_en is high the preload port
// owns the address/write path; otherwise the responder does. Contents are
// never cleared.
module i8008_bus_mem #(
   parameter int ADDR_W = 14
) (
   input  logic              clk,
   input  logic              load_en,
   input  logic              load_we,
   input  logic [ADDR_W-1:0] load_addr,
   input  logic [7:0]        load_data,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [7:0]        wdata,
   output logic [7:0]        rdata
);

   logic [7:0]        mem_r [0:(2**ADDR_W)-1];
   logic [ADDR_W-1:0] addr_s;
   logic              we_s;
   logic [7:0]        wdata_s;

   // Select between the preload port and the responder access port.
   always_comb begin
      addr_s  = addr;
      we_s    = we;
      wdata_s = wdata;
      if (load_en) begin
         addr_s  = load_addr;
         we_s    = load_we;
         wdata_s = load_data;
      end else begin
         addr_s  = addr;
         we_s    = we;
         wdata_s = wdata;
      end
   end

   // Synchronous write and registered read of the selected address.
   always_ff @(posedge clk) begin
      if (we_s) begin
         mem_r[addr_s] <= wdata_s;
      end
      rdata <= mem_r[addr_s];
   end

endmodule

// File: rtl/i8008_bus_responder.sv
// Memory and I/O responder for the i8008 core bus. Decodes T1/T2 address
// bytes, serves T3 from internal RAM or the I/O capture registers, and
// inserts WAIT_CYCLES wait states through READY.
// Optional feature macro I8008_BUS_INTR_EN: enables the INTR request latch
// and the T1I instruction jam; without it INTR is tied low and T1I acts as T1.
module i8008_bus_responder
   import i8008_pkg::*;
#(
   parameter int ADDR_W      = 14,
   parameter int WAIT_CYCLES = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   i8008_bus_responder_if.slave  bus,
   input  logic                  irq_req,
   input  logic [7:0]            irq_instr,
   input  logic                  load_we,
   input  logic [ADDR_W-1:0]     load_addr,
   input  logic [7:0]            load_data,
   output logic                  io_strobe,
   output logic [4:0]            io_port,
   output logic [7:0]            io_data
);

   localparam logic       WAIT_EN   = (WAIT_CYCLES > 0);
   localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

   state_t            state_q;
   logic [7:0]        lo_q;
   logic [5:0]        hi_q;
   cycle_t            cyc_q;
   logic              valid_r;
   logic              jam_r;
   logic [7:0]        d_in_r;
   logic              intr_r;
   logic              io_strobe_r;
   logic [4:0]        io_port_r;
   logic [7:0]        io_data_r;
   logic              entry_s, t1_entry_s, t1i_entry_s, t2_entry_s, t3_entry_s;
   logic [ADDR_W-1:0] addr_s, mem_addr_s;
   logic              mem_we_s;
   logic [7:0]        rdata_s;
   wait_state_t       wait_r, wait_d;
   logic [3:0]        cnt_r, cnt_d;
   logic              ready_r, ready_d;
   logic              unused_s;

   // State-entry detection against the previous clock's registered state.
   always_comb begin
      entry_s    = (bus.state != state_q);
      t1_entry_s = entry_s && ((bus.state == T1) || (bus.state == T1I));
      t2_entry_s = entry_s && (bus.state == T2);
      t3_entry_s = entry_s && (bus.state == T3);
`ifdef I8008_BUS_INTR_EN
      t1i_entry_s = entry_s && (bus.state == T1I);
`else
      t1i_entry_s = 1'b0;
`endif
   end

   // RAM address: look ahead to the T2 byte so read data is ready for T3.
   always_comb begin
      addr_s     = ADDR_W'({hi_q, lo_q});
      mem_addr_s = addr_s;
      if (t2_entry_s) begin
         mem_addr_s = ADDR_W'({bus.D_out[5:0], lo_q});
      end else begin
         mem_addr_s = addr_s;
      end
      mem_we_s = t3_entry_s && valid_r && (cyc_q == PCW);
   end

   i8008_bus_mem #(.ADDR_W(ADDR_W)) u_mem (
      .clk       (clk),
      .load_en   (rst),
      .load_we   (load_we),
      .load_addr (load_addr),
      .load_data (load_data),
      .we        (mem_we_s),
      .addr      (mem_addr_s),
      .wdata     (bus.D_out),
      .rdata     (rdata_s)
   );

   // Address-cycle capture and T3 service; each action fires once per entry.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= WAIT;
         lo_q        <= 8'h00;
         hi_q        <= 6'h00;
         cyc_q       <= PCI;
         valid_r     <= 1'b0;
         jam_r       <= 1'b0;
         d_in_r      <= 8'h00;
         io_strobe_r <= 1'b0;
         io_port_r   <= 5'h00;
         io_data_r   <= 8'h00;
      end else begin
         state_q     <= bus.state;
         io_strobe_r <= 1'b0;
         if (t1_entry_s) begin
            lo_q    <= bus.D_out;
            jam_r   <= t1i_entry_s;
            valid_r <= 1'b0;
         end
         if (t2_entry_s) begin
            hi_q    <= bus.D_out[5:0];
            cyc_q   <= cycle_t'(bus.D_out[7:6]);
            valid_r <= 1'b1;
         end
         if (t3_entry_s && valid_r) begin
            valid_r <= 1'b0;
            case (cyc_q)
`ifdef I8008_BUS_INTR_EN
               PCI: d_in_r <= jam_r ? irq_instr : rdata_s;
`else
               PCI: d_in_r <= rdata_s;
`endif
               PCR: d_in_r <= rdata_s;
               PCC: begin
                  if (is_inp(hi_q)) begin
                     d_in_r <= 8'h00;
                  end else begin
                     io_strobe_r <= 1'b1;
                     io_port_r   <= hi_q[5:1];
                     io_data_r   <= lo_q;
                  end
               end
               PCW:     d_in_r <= d_in_r;
               default: d_in_r <= d_in_r;
            endcase
         end
      end
   end

`ifdef I8008_BUS_INTR_EN
   // Interrupt request latch; a new request outranks the clear on T1I entry.
   always_ff @(posedge clk) begin
      if (rst) begin
         intr_r <= 1'b0;
      end else if (irq_req) begin
         intr_r <= 1'b1;
      end else if (t1i_entry_s) begin
         intr_r <= 1'b0;
      end
   end
   assign unused_s = bus.Sync;
`else
   assign intr_r   = 1'b0;
   assign unused_s = ^{bus.Sync, irq_req, irq_instr, jam_r};
`endif

   // Wait-state FSM next-state and READY decode.
   always_comb begin
      wait_d = wait_r;
      cnt_d  = cnt_r;
      case (wait_r)
         IDLE: begin
            if (t2_entry_s && WAIT_EN) begin
               wait_d = COUNT;
               cnt_d  = WAIT_LOAD;
            end else begin
               wait_d = IDLE;
            end
         end
         COUNT: begin
            if (t2_entry_s) begin
               cnt_d = WAIT_LOAD;
            end else if (cnt_r == 4'd1) begin
               wait_d = RDY;
               cnt_d  = 4'd0;
            end else begin
               cnt_d = cnt_r - 4'd1;
            end
         end
         RDY: begin
            if (t2_entry_s && WAIT_EN) begin
               wait_d = COUNT;
               cnt_d  = WAIT_LOAD;
            end else if (t3_entry_s) begin
               wait_d = IDLE;
            end else begin
               wait_d = RDY;
            end
         end
         default: begin
            wait_d = IDLE;
            cnt_d  = 4'd0;
         end
      endcase
      ready_d = (wait_d != COUNT);
   end

   // Wait-state FSM register with registered READY.
   always_ff @(posedge clk) begin
      if (rst) begin
         wait_r  <= IDLE;
         cnt_r   <= 4'd0;
         ready_r <= 1'b0;
      end else begin
         wait_r  <= wait_d;
         cnt_r   <= cnt_d;
         ready_r <= ready_d;
      end
   end

   assign bus.D_in  = d_in_r;
   assign bus.READY = ready_r;
   assign bus.INTR  = intr_r;
   assign io_strobe = io_strobe_r;
   assign io_port   = io_port_r;
   assign io_data   = io_data_r;

endmodule

// File: tb/tb_i8008_bus_responder.sv
// Directed bench: two responders (WAIT_CYCLES 0 and 3) see the same core
// stimulus; expected values are hand-computed constants.
module tb_i8008_bus_responder;
   import i8008_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  d_out;
   logic        sync;
   state_t      st;
   logic        irq_req;
   logic [7:0]  irq_instr;
   logic        load_we;
   logic [13:0] load_addr;
   logic [7:0]  load_data;
   logic        io_strobe0, io_strobe3;
   logic [4:0]  io_port0, io_port3;
   logic [7:0]  io_data0, io_data3;
   int          n_tests = 0;
   int          n_fail  = 0;

   i8008_bus_responder_if bus0();
   i8008_bus_responder_if bus3();

   assign bus0.D_out = d_out;
   assign bus0.Sync  = sync;
   assign bus0.state = st;
   assign bus3.D_out = d_out;
   assign bus3.Sync  = sync;
   assign bus3.state = st;

   i8008_bus_responder #(.ADDR_W(14), .WAIT_CYCLES(0)) dut0 (
      .clk(clk), .rst(rst), .bus(bus0.slave),
      .irq_req(irq_req), .irq_instr(irq_instr),
      .load_we(load_we), .load_addr(load_addr), .load_data(load_data),
      .io_strobe(io_strobe0), .io_port(io_port0), .io_data(io_data0)
   );

   i8008_bus_responder #(.ADDR_W(14), .WAIT_CYCLES(3)) dut3 (
      .clk(clk), .rst(rst), .bus(bus3.slave),
      .irq_req(irq_req), .irq_instr(irq_instr),
      .load_we(load_we), .load_addr(load_addr), .load_data(load_data),
      .io_strobe(io_strobe3), .io_port(io_port3), .io_data(io_data3)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic step(input state_t s, input logic [7:0] d);
      st    = s;
      d_out = d;
      tick();
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b1; d_out = 8'h00; sync = 1'b0; st = STOPPED;
      irq_req = 1'b0; irq_instr = 8'h05;
      load_we = 1'b0; load_addr = 14'h0000; load_data = 8'h00;
      tick();
      // reset state
      chk("rst_d_in",   16'(bus0.D_in),  16'h00);
      chk("rst_ready0", 16'(bus0.READY), 16'h0);
      chk("rst_ready3", 16'(bus3.READY), 16'h0);
      chk("rst_intr",   16'(bus0.INTR),  16'h0);
      chk("rst_strobe", 16'(io_strobe0), 16'h0);
      chk("rst_port",   16'(io_port0),   16'h00);
      chk("rst_data",   16'(io_data0),   16'h00);
      // preload
      load_we = 1'b1; load_addr = 14'h0000; load_data = 8'h08; tick();
      load_addr = 14'h3FFF; load_data = 8'hA5; tick();
      load_addr = 14'h0020; load_data = 8'h11; tick();
      load_we = 1'b0;
      rst = 1'b0;
      tick();
      chk("idle_ready0", 16'(bus0.READY), 16'h1);

      // PCI at address 0, no wait states
      step(T1, 8'h00);
      step(T2, 8'h00);
      chk("pci_t2_ready0", 16'(bus0.READY), 16'h1);
      step(T3, 8'h00);
      chk("pci_d_in", 16'(bus0.D_in), 16'h08);

      // PCR at 0x3FFF with three wait states
      step(T1, 8'hFF);
      step(T2, 8'h7F);
      chk("pcr_ready3_w0", 16'(bus3.READY), 16'h0);
      step(WAIT, 8'h00);
      chk("pcr_ready3_w1", 16'(bus3.READY), 16'h0);
      tick();
      chk("pcr_ready3_w2", 16'(bus3.READY), 16'h0);
      chk("pcr_ready0",    16'(bus0.READY), 16'h1);
      tick();
      chk("pcr_ready3_up", 16'(bus3.READY), 16'h1);
      step(T3, 8'h00);
      chk("pcr_d_in3", 16'(bus3.D_in), 16'hA5);
      chk("pcr_d_in0", 16'(bus0.D_in), 16'hA5);

      // PCW 0x5A to 0x0010, extra T3 clock must not rewrite
      step(T1, 8'h10);
      step(T2, 8'hC0);
      step(WAIT, 8'h00); tick(); tick();
      step(T3, 8'h5A);
      chk("pcw_no_strobe", 16'(io_strobe0), 16'h0);
      step(T3, 8'hEE);
      step(T1, 8'h10);
      step(T2, 8'h40);
      step(WAIT, 8'h00); tick(); tick();
      step(T3, 8'h00);
      chk("pcw_readback0", 16'(bus0.D_in), 16'h5A);
      chk("pcw_readback3", 16'(bus3.D_in), 16'h5A);

      // OUT: T1 0xC3, T2 10_10110_0
      step(T1, 8'hC3);
      step(T2, 8'hAC);
      step(WAIT, 8'h00); tick(); tick();
      step(T3, 8'h00);
      chk("out_strobe", 16'(io_strobe0), 16'h1);
      chk("out_port",   16'(io_port0),   16'h16);
      chk("out_data",   16'(io_data0),   16'hC3);
      chk("out_port3",  16'(io_port3),   16'h16);
      tick();
      chk("out_strobe_once", 16'(io_strobe0), 16'h0);

      // INP returns zero
      step(T1, 8'h00);
      step(T2, 8'h80);
      step(WAIT, 8'h00); tick(); tick();
      step(T3, 8'h00);
      chk("inp_d_in", 16'(bus0.D_in), 16'h00);

      // interrupt request and T1I
      irq_req = 1'b1; tick();
      irq_req = 1'b0;
`ifdef I8008_BUS_INTR_EN
      chk("intr_set", 16'(bus0.INTR), 16'h1);
      tick();
      chk("intr_hold", 16'(bus0.INTR), 16'h1);
`else
      chk("intr_tied", 16'(bus0.INTR), 16'h0);
      tick();
`endif
      step(T1I, 8'h00);
      chk("intr_clear", 16'(bus0.INTR), 16'h0);
      step(T2, 8'h00);
      step(WAIT, 8'h00); tick(); tick();
      step(T3, 8'h00);
`ifdef I8008_BUS_INTR_EN
      chk("jam_d_in", 16'(bus0.D_in), 16'h05);
      step(T1, 8'h00);
      irq_req = 1'b1;
      step(T1I, 8'h00);
      irq_req = 1'b0;
      chk("intr_set_wins", 16'(bus0.INTR), 16'h1);
`else
      chk("t1i_fetch_d_in", 16'(bus0.D_in), 16'h08);
`endif

      // reset during WAIT of a PCW to 0x0020 aborts it
      step(T1, 8'h20);
      step(T2, 8'hC0);
      step(WAIT, 8'h00);
      chk("abort_wait_ready3", 16'(bus3.READY), 16'h0);
      rst = 1'b1; tick();
      chk("abort_rst_ready3", 16'(bus3.READY), 16'h0);
      chk("abort_rst_ready0", 16'(bus0.READY), 16'h0);
      chk("abort_rst_d_in",   16'(bus0.D_in),  16'h00);
      rst = 1'b0;
      step(T3, 8'h77);
      chk("abort_no_strobe", 16'(io_strobe0), 16'h0);
      chk("abort_idle_ready3", 16'(bus3.READY), 16'h1);
      chk("abort_no_d_in",   16'(bus0.D_in), 16'h00);
      step(T3, 8'h77);
      step(T1, 8'h20);
      step(T2, 8'h40);
      chk("fresh_ready3_low", 16'(bus3.READY), 16'h0);
      step(WAIT, 8'h00); tick(); tick();
      chk("fresh_ready3_up", 16'(bus3.READY), 16'h1);
      step(T3, 8'h00);
      chk("fresh_no_write0", 16'(bus0.D_in), 16'h11);
      chk("fresh_no_write3", 16'(bus3.D_in), 16'h11);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
